mmio_periph: RTL and testbench
==============================

// Module: mmio_periph
// PURPOSE
//  Memory-mapped peripheral slave downstream of the pipeline's MEM stage.
//  It decodes the data-bus window at BASE_ADDR and holds a reloadable timer with interrupt, the LED latch,
//  and a 4-digit hex 7-segment scanner. It also holds an optional free-running tick counter.
//  It produces rdata/hit for the MEM-stage read mux and drives board pins led/AN/BCD.
// PARAMETERS
//  BASE_ADDR  32'h4000_0000  word-aligned base of 6-word register window
//  SCAN_DIV   100000         clk cycles each digit is lit (>=2)
// PORTS
//  clk        in   1   system clock, all state on posedge
//  reset      in   1   asynchronous, active-low (0 = reset)
//  addr       in   32  byte address from MEM stage ALU result
//  wdata      in   32  store data
//  mem_read   in   1   load strobe
//  mem_write  in   1   store strobe
//  rdata      out  32  read data, combinational
//  hit        out  1   addr inside window (BASE_ADDR..BASE_ADDR+0x17)
//  irq        out  1   timer interrupt request, level
//  led        out  16  LED latch
//  AN         out  4   digit anodes, active-low one-hot
//  BCD        out  8   segments {dp,g,f,e,d,c,b,a}, active-low
// BEHAVIOUR
//  Register map (offset, addr[1:0] ignored):
//   0x00 TH   rw 32  timer reload value
//   0x04 TL   rw 32  timer count
//   0x08 TCON rw 3   [0]=enable [1]=irq_en [2]=irq_status (write 1 clears)
//   0x0C LED  rw 16
//   0x10 DISP rw 16  four hex nibbles, digit0 = [3:0]
//   0x14 TICK ro 32  free-running cycle count (see CONFIGURATION)
//  Reset (reset=0, async): TH=TL=0, TCON=0, LED=0, DISP=0, TICK=0, scan counter=0, digit=0.
//   Outputs during reset: led=0, AN=4'b1110, BCD=8'hC0, irq=0.
//  Read: rdata = selected reg zero-extended when mem_read&hit, else 32'h0; no latency.
//  Write: takes effect at the posedge when mem_write&hit. Writes to TICK or unmapped offsets are ignored.
//  Timer, each cycle with TCON[0]=1:
//   TL!=32'hFFFF_FFFF: TL<=TL+1.
//   TL==32'hFFFF_FFFF: TL<=TH. If TCON[1], set TCON[2].
//  Same-cycle TL write and increment: the written value wins, with no increment that cycle.
//  Same-cycle TCON write clearing [2] and an overflow setting it: the set wins, so the event is not lost.
//   Bits [1:0] still take the written value.
//  irq = TCON[2] & TCON[1]. Clearing irq_en masks irq but keeps status.
//  Scanner:
//   Prescaler counts 0..SCAN_DIV-1. At SCAN_DIV-1 it wraps to 0 and digit advances 0->1->2->3->0.
//   AN = ~(4'b0001<<digit). BCD = hex7seg(DISP nibble[digit]) with dp off (bit7=1).
//   Hex table (active-low) 0..F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.
//   A DISP write is visible from the next cycle and does not reset the scan.
//  led = LED register, registered output.
//  Reset asserted mid-operation immediately returns all state to reset values.
// CONFIGURATION
//  SYSTICK_EN defined:
//   TICK increments every cycle from reset and wraps at 2^32 to 0.
//   Reads at 0x14 return TICK.
//  SYSTICK_EN undefined:
//   TICK logic is absent. Reads at 0x14 return 32'h0. hit still covers 0x14.
// TESTING
//  Reset check: after reset release, read all regs -> 0. AN=1110, BCD=C0, irq=0.
//  Timer reload: TH=FFFF_FFFC, TL=FFFF_FFFE, TCON=3 -> TL FFFF_FFFF next cycle, then FFFF_FFFC.
//   TCON reads 7 and irq=1 from the reload edge.
//  W1C vs overflow: write TCON=3'b111 on the overflow cycle -> status stays 1.
//   Write TCON=3'b111 on a later cycle -> status 0, irq=0.
//  Display: SCAN_DIV=4, DISP=16'h1A3F.
//   AN sequence 1110,1101,1011,0111 every 4 cycles.
//   BCD sequence 8E,B0,88,F9.
//  Decode: write LED 16'hBEEF at BASE+0x0C -> led=BEEF.
//   Write to BASE+0x18 -> hit=0, no state change.
//   mem_read=0 -> rdata=0.
//  SYSTICK_EN both builds: read 0x14 at 100 cycles after reset release -> 100 (defined) / 0 (undefined).

Source files
------------

// File: rtl/mmio_periph.sv
// MMIO slave at BASE_ADDR: reload timer with IRQ, LED latch, 4-digit hex scanner; reads are combinational, writes land on posedge.
// Optional free-running TICK counter at offset 0x14 is built only when SYSTICK_EN is defined.
module mmio_periph #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          SCAN_DIV  = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        irq,
  output logic [15:0] led,
  output logic [3:0]  AN,
  output logic [7:0]  BCD
);

  localparam int PW = $clog2(SCAN_DIV);

  logic [31:0]   off;
  logic [2:0]    idx;
  logic          wr;
  logic          ovf;
  logic [31:0]   tick;
  logic [31:0]   th_q, th_d, tl_q, tl_d;
  logic [2:0]    tcon_q, tcon_d;
  logic [15:0]   led_q, led_d, disp_q, disp_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    digit_q, digit_d;

  // Offset arithmetic makes the window test a single unsigned compare.
  assign off = addr - BASE_ADDR;
  assign hit = (off < 32'h18);
  assign idx = off[4:2];
  assign wr  = mem_write & hit;
  assign ovf = tcon_q[0] & (tl_q == 32'hFFFF_FFFF);

  always_comb begin
    th_d    = th_q;
    tl_d    = tl_q;
    tcon_d  = tcon_q;
    led_d   = led_q;
    disp_d  = disp_q;
    presc_d = presc_q + PW'(1);
    digit_d = digit_q;
    if (tcon_q[0]) tl_d = ovf ? th_q : tl_q + 32'd1;
    if (wr) begin
      case (idx)
        3'd0:    th_d   = wdata;
        3'd1:    tl_d   = wdata;
        3'd2:    tcon_d = {tcon_q[2] & ~wdata[2], wdata[1:0]};
        3'd3:    led_d  = wdata[15:0];
        3'd4:    disp_d = wdata[15:0];
        default: ;
      endcase
    end
    // Overflow status set is applied after the W1C so a coincident clear cannot drop the event.
    if (ovf & tcon_q[1]) tcon_d[2] = 1'b1;
    if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_d = '0;
      digit_d = digit_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_q    <= '0;
      tl_q    <= '0;
      tcon_q  <= '0;
      led_q   <= '0;
      disp_q  <= '0;
      presc_q <= '0;
      digit_q <= '0;
    end else begin
      th_q    <= th_d;
      tl_q    <= tl_d;
      tcon_q  <= tcon_d;
      led_q   <= led_d;
      disp_q  <= disp_d;
      presc_q <= presc_d;
      digit_q <= digit_d;
    end
  end

`ifdef SYSTICK_EN
  logic [31:0] tick_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tick_q <= '0;
    else        tick_q <= tick_q + 32'd1;
  end
  assign tick = tick_q;
`else
  assign tick = 32'h0;
`endif

  always_comb begin
    rdata = 32'h0;
    if (mem_read & hit) begin
      case (idx)
        3'd0:    rdata = th_q;
        3'd1:    rdata = tl_q;
        3'd2:    rdata = {29'h0, tcon_q};
        3'd3:    rdata = {16'h0, led_q};
        3'd4:    rdata = {16'h0, disp_q};
        3'd5:    rdata = tick;
        default: rdata = 32'h0;
      endcase
    end
  end

  function automatic logic [7:0] hex7seg(input logic [3:0] n);
    case (n)
      4'h0: hex7seg = 8'hC0;
      4'h1: hex7seg = 8'hF9;
      4'h2: hex7seg = 8'hA4;
      4'h3: hex7seg = 8'hB0;
      4'h4: hex7seg = 8'h99;
      4'h5: hex7seg = 8'h92;
      4'h6: hex7seg = 8'h82;
      4'h7: hex7seg = 8'hF8;
      4'h8: hex7seg = 8'h80;
      4'h9: hex7seg = 8'h90;
      4'hA: hex7seg = 8'h88;
      4'hB: hex7seg = 8'h83;
      4'hC: hex7seg = 8'hC6;
      4'hD: hex7seg = 8'hA1;
      4'hE: hex7seg = 8'h86;
      default: hex7seg = 8'h8E;
    endcase
  endfunction

  assign irq = tcon_q[2] & tcon_q[1];
  assign led = led_q;
  assign AN  = ~(4'b0001 << digit_q);
  assign BCD = hex7seg(disp_q[{digit_q, 2'b00} +: 4]);

endmodule

// File: tb/tb_mmio_periph.sv
// Directed bench for mmio_periph with a per-cycle behavioural model and literal spot checks.
`timescale 1ns/1ps
module tb_mmio_periph;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int          DIV  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = '0, wdata = '0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [31:0] rdata;
  logic        hit, irq;
  logic [15:0] led;
  logic [3:0]  AN;
  logic [7:0]  BCD;

  mmio_periph #(.BASE_ADDR(BASE), .SCAN_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
    .mem_read(mem_read), .mem_write(mem_write), .rdata(rdata),
    .hit(hit), .irq(irq), .led(led), .AN(AN), .BCD(BCD)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  // Model state: registers as the programmer sees them, plus cycles since reset.
  logic [31:0] m_th, m_tl, m_tick;
  logic [2:0]  m_tcon;
  logic [15:0] m_led, m_disp;
  int unsigned m_cyc;
  logic [7:0]  seg [0:15] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  function automatic bit in_win(input logic [31:0] a);
    return (a >= BASE) && (a <= BASE + 32'd23);
  endfunction

  function automatic int reg_of(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic bit wr_to(input int r);
    return mem_write && in_win(addr) && (reg_of(addr) == r);
  endfunction

  function automatic logic [31:0] f_tl_next();
    logic [31:0] n = m_tl;
    if (m_tcon[0]) n = (m_tl == 32'hFFFF_FFFF) ? m_th : m_tl + 32'd1;
    if (wr_to(1)) n = wdata;
    return n;
  endfunction

  function automatic logic [2:0] f_tcon_next();
    logic [2:0] n = m_tcon;
    if (wr_to(2)) n = {m_tcon[2] & ~wdata[2], wdata[1:0]};
    if (m_tcon[0] && m_tcon[1] && m_tl == 32'hFFFF_FFFF) n[2] = 1'b1;
    return n;
  endfunction

  function automatic logic [31:0] exp_rdata();
    if (!(mem_read && in_win(addr))) return 32'h0;
    case (reg_of(addr))
      0: return m_th;
      1: return m_tl;
      2: return {29'h0, m_tcon};
      3: return {16'h0, m_led};
      4: return {16'h0, m_disp};
      default: begin
`ifdef SYSTICK_EN
        return m_tick;
`else
        return 32'h0;
`endif
      end
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_th <= '0; m_tl <= '0; m_tcon <= '0; m_led <= '0; m_disp <= '0;
      m_cyc <= 0; m_tick <= '0;
    end else begin
      m_tl   <= f_tl_next();
      m_tcon <= f_tcon_next();
      if (wr_to(0)) m_th   <= wdata;
      if (wr_to(3)) m_led  <= wdata[15:0];
      if (wr_to(4)) m_disp <= wdata[15:0];
      m_cyc  <= m_cyc + 1;
      m_tick <= m_tick + 32'd1;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      int d;
      d = int'((m_cyc / DIV) % 4);
      check("m_hit",   {31'h0, hit}, {31'h0, in_win(addr)});
      check("m_rdata", rdata, exp_rdata());
      check("m_irq",   {31'h0, irq}, {31'h0, m_tcon[2] & m_tcon[1]});
      check("m_led",   {16'h0, led}, {16'h0, m_led});
      check("m_AN",    {28'h0, AN}, {28'h0, ~(4'b0001 << d)});
      check("m_BCD",   {24'h0, BCD}, {24'h0, seg[m_disp[4*d +: 4]]});
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; mem_write = 1'b1; mem_read = 1'b0;
    step();
    mem_write = 1'b0;
  endtask

  task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
    addr = a; mem_read = 1'b1; #1;
    check(nm, rdata, exp);
    mem_read = 1'b0;
  endtask

  logic [3:0]  an_exp  [0:4] = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};
  logic [7:0]  bcd_exp [0:4] = '{8'h8E, 8'hB0, 8'h88, 8'hF9, 8'h8E};
  int          k_at    [0:4] = '{3, 4, 8, 12, 16};

  initial begin
    #2 reset = 1'b0;
    chk_en = 1'b1;
    #4 reset = 1'b1;
    check("rst_AN",  {28'h0, AN}, 32'hE);
    check("rst_BCD", {24'h0, BCD}, 32'hC0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    for (int i = 0; i < 6; i++) rd("rst_reg", BASE + 32'(4 * i), 32'h0);

    repeat (100) @(posedge clk);
    #1;
`ifdef SYSTICK_EN
    rd("tick100", BASE + 32'h14, 32'd100);
`else
    rd("tick100", BASE + 32'h14, 32'd0);
`endif

    wr(BASE + 32'h0, 32'hFFFF_FFFC);
    wr(BASE + 32'h4, 32'hFFFF_FFFE);
    wr(BASE + 32'h8, 32'h3);
    rd("tl_start", BASE + 32'h4, 32'hFFFF_FFFE);
    step();
    rd("tl_max", BASE + 32'h4, 32'hFFFF_FFFF);
    step();
    rd("tl_reload", BASE + 32'h4, 32'hFFFF_FFFC);
    rd("tcon_ovf", BASE + 32'h8, 32'h7);
    check("irq_ovf", {31'h0, irq}, 32'h1);
    wr(BASE + 32'h8, 32'h7);
    rd("tcon_w1c", BASE + 32'h8, 32'h3);
    check("irq_w1c", {31'h0, irq}, 32'h0);
    step();
    step();
    rd("tl_max2", BASE + 32'h4, 32'hFFFF_FFFF);
    wr(BASE + 32'h8, 32'h7);
    rd("tcon_setwins", BASE + 32'h8, 32'h7);
    check("irq_setwins", {31'h0, irq}, 32'h1);
    wr(BASE + 32'h4, 32'h5);
    rd("tl_wr_wins", BASE + 32'h4, 32'h5);
    step();
    rd("tl_inc", BASE + 32'h4, 32'h6);
    wr(BASE + 32'h8, 32'h1);
    rd("tcon_mask", BASE + 32'h8, 32'h5);
    check("irq_mask", {31'h0, irq}, 32'h0);
    wr(BASE + 32'h8, 32'h4);
    rd("tcon_off", BASE + 32'h8, 32'h0);
    step();
    rd("tl_frozen", BASE + 32'h4, 32'h8);

    wr(BASE + 32'hC, 32'h1234_BEEF);
    check("led_beef", {16'h0, led}, 32'hBEEF);
    addr = BASE + 32'h18; wdata = 32'hDEAD_0000; mem_write = 1'b1; mem_read = 1'b1; #1;
    check("hit_18", {31'h0, hit}, 32'h0);
    check("rd_18", rdata, 32'h0);
    step();
    mem_write = 1'b0; mem_read = 1'b0;
    rd("th_kept", BASE + 32'h0, 32'hFFFF_FFFC);
    check("led_kept", {16'h0, led}, 32'hBEEF);
    addr = BASE + 32'hC; #1;
    check("rd_noread", rdata, 32'h0);
    check("hit_14", {31'h0, hit}, 32'h0 + {31'h0, in_win(BASE + 32'h14)} & 32'h1);
    addr = BASE - 32'h4; #1;
    check("hit_below", {31'h0, hit}, 32'h0);

    wr(BASE + 32'h8, 32'h3);
    reset = 1'b0; #1;
    check("mid_led", {16'h0, led}, 32'h0);
    check("mid_AN",  {28'h0, AN}, 32'hE);
    check("mid_BCD", {24'h0, BCD}, 32'hC0);
    check("mid_irq", {31'h0, irq}, 32'h0);
    addr = BASE + 32'h10; wdata = 32'h0000_1A3F; mem_write = 1'b1;
    #1 reset = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 1) mem_write = 1'b0;
      for (int j = 0; j < 5; j++) begin
        if (k_at[j] == k) begin
          check("scan_AN",  {28'h0, AN}, {28'h0, an_exp[j]});
          check("scan_BCD", {24'h0, BCD}, {24'h0, bcd_exp[j]});
        end
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
